// File: rtl/bt_uart_pkg.sv
// Shared definitions for the HC-05 UART receive/transmit pair.
// State encoding and default baud constants live here so both directions agree.
package bt_uart_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam int CLK_HZ       = 1_000_000;
   localparam int BAUD         = 9600;
   localparam int CLKS_PER_BIT = 104;

   // Start bit is confirmed at its midpoint, half a bit period after the edge.
   function automatic int half_bit(input int cpb);
      return cpb / 2;
   endfunction

endpackage

// File: rtl/bt_byte_fifo.sv
// First-word-fall-through byte FIFO; head is combinational from the read pointer.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module bt_byte_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                           clock,
   input  logic                           resetn,
   input  logic                           wr_en,
   input  logic [WIDTH-1:0]               din,
   input  logic                           rd_en,
   output logic [WIDTH-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full,
   output logic                           empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = rd_en & ~empty;
   assign do_push = wr_en & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // When full, wr_ptr == rd_ptr: the write lands in the slot being popped.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1 receiver for the HC-05 TXD line: synchroniser, mid-bit sampling FSM,
// byte FIFO and sticky error flags for debug wire-outs.
module bt_uart_rx #(
   parameter int CLKS_PER_BIT = bt_uart_pkg::CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                               clock,
   input  logic                               resetn,
   input  logic                               rxd,
   input  logic                               rd_en,
   input  logic                               clear_errors,
   output logic [7:0]                         data_out,
   output logic                               data_valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               framing_error,
   output logic                               overflow,
   output logic                               rx_busy
);

   import bt_uart_pkg::*;

   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(half_bit(CLKS_PER_BIT) - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   logic [1:0]    sync;
   logic          rxs;
   logic          rxs_prev;
   logic          fall;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          sample_tick;
   logic          stop_ok;
   logic          stop_bad;
   logic          push_q;
   logic          fifo_full;
   logic          fifo_empty;

   // Flops reset to the idle level so reset release never looks like a start edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync     <= 2'b11;
         rxs_prev <= 1'b1;
      end else begin
         sync     <= {sync[0], rxd};
         rxs_prev <= sync[1];
      end
   end

   assign rxs  = sync[1];
   assign fall = rxs_prev & ~rxs;

   assign sample_tick = (state == ST_START) ? (cnt == HALF_M1)
                                            : ((state != ST_IDLE) && (cnt == FULL_M1));

   always_comb begin
      state_nxt = state;
      stop_ok   = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         ST_IDLE:  if (fall) state_nxt = ST_START;
         ST_START: if (sample_tick) state_nxt = rxs ? ST_IDLE : ST_DATA;
         ST_DATA:  if (sample_tick && (bit_idx == 3'd7)) state_nxt = ST_STOP;
         ST_STOP: begin
            if (sample_tick) begin
               state_nxt = ST_IDLE;
               stop_ok   = rxs;
               stop_bad  = ~rxs;
            end
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         push_q  <= 1'b0;
         rx_busy <= 1'b0;
      end else begin
         state   <= state_nxt;
         rx_busy <= (state_nxt != ST_IDLE);
         push_q  <= stop_ok;
         if ((state == ST_IDLE) || sample_tick) cnt <= '0;
         else                                   cnt <= cnt + CW'(1);
         if ((state == ST_IDLE) && fall) bit_idx <= '0;
         if ((state == ST_DATA) && sample_tick) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   // shreg is stable for the cycle after the stop sample, so it feeds the FIFO directly.
   bt_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .wr_en  (push_q),
      .din    (shreg),
      .rd_en  (rd_en),
      .dout   (data_out),
      .count  (fifo_count),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign data_valid = ~fifo_empty;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         framing_error <= 1'b0;
         overflow      <= 1'b0;
      end else if (clear_errors) begin
         framing_error <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         if (stop_bad)                        framing_error <= 1'b1;
         if (push_q && fifo_full && !rd_en)   overflow      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bt_uart_rx.sv
// Self-checking bench for bt_uart_rx: table vectors, directed corner sequences,
// and random frames checked against a queue-based model of the receiver.
module tb_bt_uart_rx;

   localparam int CPB   = 104;
   localparam int DEPTH = 8;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       rxd = 1'b1;
   logic       rd_en = 1'b0;
   logic       clear_errors = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic [3:0] fifo_count;
   logic       framing_error;
   logic       overflow;
   logic       rx_busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_count;
      logic [7:0] exp_head;
      logic       exp_ferr;
   } vec_t;

   bt_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .rxd           (rxd),
      .rd_en         (rd_en),
      .clear_errors  (clear_errors),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .fifo_count    (fifo_count),
      .framing_error (framing_error),
      .overflow      (overflow),
      .rx_busy       (rx_busy)
   );

   always #5 clock = ~clock;

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input logic stop, input int nbits);
      rxd = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < nbits; i++) begin
         rxd = b[i];
         repeat (CPB) tick();
      end
      if (nbits == 8) begin
         rxd = stop;
         repeat (CPB) tick();
      end
      rxd = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
      send_bits(b, stop, 8);
      repeat (gap) tick();
   endtask

   task automatic pop_expect(input string nm, input logic [7:0] exp);
      chk({nm, "_valid"}, int'(data_valid), 1);
      chk(nm, int'(data_out), int'(exp));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic clear_flags();
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
   endtask

   task automatic chk_idle_state(input string nm, input int cnt, input int ferr, input int ovf);
      chk({nm, "_count"}, int'(fifo_count), cnt);
      chk({nm, "_ferr"},  int'(framing_error), ferr);
      chk({nm, "_ovf"},   int'(overflow), ovf);
      chk({nm, "_busy"},  int'(rx_busy), 0);
   endtask

   initial begin
      vec_t       vecs[6];
      int         lat;
      bit         found;
      logic [7:0] q[$];
      logic       mf;
      logic       mo;
      logic [7:0] d;
      logic       st;
      int         k;

      vecs[0] = '{8'h3C, 1'b0, 0, 8'h00, 1'b1};
      vecs[1] = '{8'h55, 1'b1, 1, 8'h55, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 1, 8'h00, 1'b0};
      vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b0};
      vecs[4] = '{8'h81, 1'b0, 0, 8'h00, 1'b1};
      vecs[5] = '{8'h6E, 1'b1, 1, 8'h6E, 1'b0};

      // reset values
      repeat (3) tick();
      chk("rst_valid", int'(data_valid), 0);
      chk_idle_state("rst", 0, 0, 0);
      resetn = 1'b1;
      repeat (5) tick();

      // first byte: start detection and latency
      fork
         send_bits(8'hA5, 1'b1, 8);
         begin
            tick(); tick();
            chk("busy_before_start", int'(rx_busy), 0);
            tick();
            chk("busy_at_start", int'(rx_busy), 1);
            lat = 3;
            found = 1'b0;
            for (int i = 0; i < 1100 && !found; i++) begin
               tick();
               lat++;
               if (data_valid) found = 1'b1;
            end
            chk("latency_seen", int'(found), 1);
            chk("latency_window", int'(lat >= 991 && lat <= 992), 1);
         end
      join
      repeat (10) tick();
      chk_idle_state("a5", 1, 0, 0);
      pop_expect("a5_head", 8'hA5);
      chk("a5_empty", int'(data_valid), 0);

      // table vectors, each from an empty FIFO with flags cleared
      for (int i = 0; i < 6; i++) begin
         clear_flags();
         send_byte(vecs[i].data, vecs[i].stop, 20);
         chk($sformatf("vec%0d_count", i), int'(fifo_count), vecs[i].exp_count);
         chk($sformatf("vec%0d_ferr", i), int'(framing_error), int'(vecs[i].exp_ferr));
         chk($sformatf("vec%0d_ovf", i), int'(overflow), 0);
         if (vecs[i].exp_count != 0) pop_expect($sformatf("vec%0d_head", i), vecs[i].exp_head);
      end

      // ten back-to-back bytes into an 8-deep FIFO
      clear_flags();
      for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b1, 0);
      repeat (20) tick();
      chk_idle_state("ovf", 8, 0, 1);
      for (int i = 0; i < 8; i++) pop_expect($sformatf("ovf_pop%0d", i), 8'(i));
      chk("ovf_drained", int'(data_valid), 0);

      // short low glitch is a false start
      clear_flags();
      rxd = 1'b0;
      repeat (20) tick();
      rxd = 1'b1;
      repeat (10) tick();
      chk("glitch_busy", int'(rx_busy), 1);
      repeat (100) tick();
      chk_idle_state("glitch", 0, 0, 0);

      // full FIFO with a pop on the push cycle
      for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b1, 20);
      chk("full_count", int'(fifo_count), 8);
      fork
         send_bits(8'h99, 1'b1, 8);
         begin
            repeat (991) tick();
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
         end
      join
      repeat (5) tick();
      chk("fullpop_count", int'(fifo_count), 8);
      chk("fullpop_ovf", int'(overflow), 0);
      for (int i = 1; i < 8; i++) pop_expect($sformatf("fullpop%0d", i), 8'(8'h10 + i));
      pop_expect("fullpop_last", 8'h99);
      chk("fullpop_drained", int'(data_valid), 0);

      // reset in the middle of a frame
      send_byte(8'h77, 1'b1, 20);
      send_byte(8'h3C, 1'b0, 20);
      send_bits(8'h5A, 1'b1, 4);
      chk("midrst_busy_pre", int'(rx_busy), 1);
      #2 resetn = 1'b0;
      #1;
      chk("midrst_valid", int'(data_valid), 0);
      chk_idle_state("midrst", 0, 0, 0);
      tick(); tick();
      resetn = 1'b1;
      repeat (20) tick();
      send_byte(8'hC3, 1'b1, 20);
      chk_idle_state("c3", 1, 0, 0);
      pop_expect("c3_head", 8'hC3);

      // clear_errors wins over a framing error on the same cycle
      fork
         send_bits(8'h3C, 1'b0, 8);
         begin
            repeat (990) tick();
            clear_errors = 1'b1;
            tick();
            clear_errors = 1'b0;
         end
      join
      repeat (20) tick();
      chk("clr_prio_ferr", int'(framing_error), 0);
      chk("clr_prio_count", int'(fifo_count), 0);

      // random frames against a queue model
      mf = 1'b0;
      mo = 1'b0;
      for (int n = 0; n < 16; n++) begin
         d  = 8'($urandom);
         st = ($urandom_range(0, 4) != 0);
         send_byte(d, st, 20);
         if (!st)                  mf = 1'b1;
         else if (q.size() < DEPTH) q.push_back(d);
         else                      mo = 1'b1;
         chk($sformatf("rnd%0d_count", n), int'(fifo_count), q.size());
         chk($sformatf("rnd%0d_ferr", n), int'(framing_error), int'(mf));
         chk($sformatf("rnd%0d_ovf", n), int'(overflow), int'(mo));
         k = $urandom_range(0, 1);
         for (int j = 0; j < k; j++) begin
            if (q.size() > 0) pop_expect($sformatf("rnd%0d_pop", n), q.pop_front());
            else begin
               rd_en = 1'b1;
               tick();
               rd_en = 1'b0;
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            clear_flags();
            mf = 1'b0;
            mo = 1'b0;
         end
      end
      chk("rnd_final_count", int'(fifo_count), q.size());
      while (q.size() > 0) pop_expect("rnd_drain", q.pop_front());
      chk("rnd_final_empty", int'(data_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
